// File: rtl/branch_info_queue_if.sv
// Bundle of decode push, ROB commit/flush and predictor feedback signals for the branch info queue.
// master = decode/ROB/predictor side, slave = the queue itself.
// Purely structural; no timing of its own.
interface branch_info_queue_if #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int GH_BITS    = 10
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  push_valid;
  logic [ADDR_WIDTH-1:0] push_pc;
  logic [GH_BITS-1:0]    push_ghistory;
  logic                  push_pred;
  logic                  push_pred_gs;
  logic                  push_pred_2b;
  logic                  push_ready;

  logic                  commit_valid;
  logic                  commit_outcome;
  logic                  flush;

  logic                  fb_valid;
  logic [ADDR_WIDTH-1:0] fb_pc;
  logic [GH_BITS-1:0]    fb_ghistory;
  logic                  fb_pred;
  logic                  fb_pred_gs;
  logic                  fb_pred_2b;
  logic                  fb_outcome;
  logic                  fb_mispredict;

  logic [CNT_W-1:0]      count;
  logic                  underflow_err;

  modport master (
    output push_valid, push_pc, push_ghistory, push_pred, push_pred_gs, push_pred_2b,
    output commit_valid, commit_outcome, flush,
    input  push_ready,
    input  fb_valid, fb_pc, fb_ghistory, fb_pred, fb_pred_gs, fb_pred_2b, fb_outcome, fb_mispredict,
    input  count, underflow_err
  );

  modport slave (
    input  push_valid, push_pc, push_ghistory, push_pred, push_pred_gs, push_pred_2b,
    input  commit_valid, commit_outcome, flush,
    output push_ready,
    output fb_valid, fb_pc, fb_ghistory, fb_pred, fb_pred_gs, fb_pred_2b, fb_outcome, fb_mispredict,
    output count, underflow_err
  );
endinterface

// File: rtl/branch_info_queue.sv
// In-order queue of branch prediction records from decode to ROB commit, feeding predictor training.
// Latency: feedback record is registered, one cycle after the committing edge.
// Backpressure: push_ready drops when full (pre-edge count); a push while full is dropped.
module branch_info_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int GH_BITS    = 10
) (
  input logic                clk,
  input logic                rst_n,
  branch_info_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [GH_BITS-1:0]    ghistory;
    logic                  pred;
    logic                  pred_gs;
    logic                  pred_2b;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  entry_t           head_ent;
  entry_t           push_ent;
  logic             full;
  logic             empty;
  logic             pop;
  logic             mispredict;
  logic             squash;
  logic             push_fire;

  entry_t           fb_ent;
  logic             fb_valid;
  logic             fb_outcome;
  logic             fb_mispredict;
  logic             underflow_err;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_ent   = mem[head];
  assign pop        = bus.commit_valid & ~empty;
  // A mispredicting commit means everything younger was fetched down the wrong path.
  assign mispredict = pop & (head_ent.pred != bus.commit_outcome);
  assign squash     = bus.flush | mispredict;
  assign push_fire  = bus.push_valid & ~full & ~squash;

  assign push_ent.pc       = bus.push_pc;
  assign push_ent.ghistory = bus.push_ghistory;
  assign push_ent.pred     = bus.push_pred;
  assign push_ent.pred_gs  = bus.push_pred_gs;
  assign push_ent.pred_2b  = bus.push_pred_2b;

  // Entry storage: write the pushed record at the tail slot (no reset needed, guarded by count).
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[tail] <= push_ent;
    end
  end

  // Pointer and occupancy update; a squash empties the queue and swallows the same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push_fire) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push_fire) - CNT_W'(pop);
    end
  end

  // Feedback record: pulse valid on a pop, otherwise hold the last record's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_valid      <= 1'b0;
      fb_ent        <= '0;
      fb_outcome    <= 1'b0;
      fb_mispredict <= 1'b0;
    end else begin
      fb_valid <= pop;
      if (pop) begin
        fb_ent        <= head_ent;
        fb_outcome    <= bus.commit_outcome;
        fb_mispredict <= mispredict;
      end
    end
  end

  // Sticky error flag for a commit arriving with nothing queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err <= 1'b0;
    end else if (bus.commit_valid && empty) begin
      underflow_err <= 1'b1;
    end
  end

  assign bus.push_ready    = ~full;
  assign bus.count         = count;
  assign bus.fb_valid      = fb_valid;
  assign bus.fb_pc         = fb_ent.pc;
  assign bus.fb_ghistory   = fb_ent.ghistory;
  assign bus.fb_pred       = fb_ent.pred;
  assign bus.fb_pred_gs    = fb_ent.pred_gs;
  assign bus.fb_pred_2b    = fb_ent.pred_2b;
  assign bus.fb_outcome    = fb_outcome;
  assign bus.fb_mispredict = fb_mispredict;
  assign bus.underflow_err = underflow_err;
endmodule
